// File: rtl/wb_pkg.sv
// Shared types for the write-back / load-store stage: op classes and FSM states.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_OP_NONE  = 2'b00,
    WB_OP_ALU   = 2'b01,
    WB_OP_STORE = 2'b10,
    WB_OP_LOAD  = 2'b11
  } wb_op_e;

  typedef enum logic [1:0] {
    WB_IDLE    = 2'b00,
    WB_ST_REQ  = 2'b01,
    WB_LD_REQ  = 2'b10,
    WB_LD_WAIT = 2'b11
  } wb_state_e;

endpackage

// File: rtl/wb_lsu_stage_if.sv
// Bundle of EX handshake, data-bus and regfile write-port signals around the stage.
interface wb_lsu_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  import wb_pkg::*;

  logic                ex_valid;
  logic                ex_ready;
  wb_op_e              ex_op;
  logic [REG_AW-1:0]   ex_rd;
  logic [XLEN-1:0]     ex_result;
  logic [XLEN-1:0]     ex_wdata;
  logic [XLEN/8-1:0]   ex_be;

  logic                dbus_req;
  logic                dbus_we;
  logic [XLEN-1:0]     dbus_addr;
  logic [XLEN-1:0]     dbus_wdata;
  logic [XLEN/8-1:0]   dbus_be;
  logic                dbus_gnt;
  logic                dbus_rvalid;
  logic [XLEN-1:0]     dbus_rdata;

  logic                wr_rd_en;
  logic [REG_AW-1:0]   wr_rd_addr;
  logic [XLEN-1:0]     wr_rd_data;
  logic [CNT_W-1:0]    retired_cnt;

  modport slave (
    input  ex_valid, ex_op, ex_rd, ex_result, ex_wdata, ex_be,
    input  dbus_gnt, dbus_rvalid, dbus_rdata,
    output ex_ready,
    output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    output wr_rd_en, wr_rd_addr, wr_rd_data, retired_cnt
  );

  modport master (
    output ex_valid, ex_op, ex_rd, ex_result, ex_wdata, ex_be,
    output dbus_gnt, dbus_rvalid, dbus_rdata,
    input  ex_ready,
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    input  wr_rd_en, wr_rd_addr, wr_rd_data, retired_cnt
  );

endinterface

// File: rtl/wb_lsu_stage.sv
// Write-back stage: ALU results stream straight to the regfile, loads/stores run
// one req/gnt/rvalid data-bus transaction each. All outputs come from flops.
module wb_lsu_stage
  import wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  wb_lsu_stage_if.slave  bus
);

  localparam int BW = XLEN / 8;

  wb_state_e          r_state;
  wb_state_e          w_state_nxt;

  logic               w_accept;
  logic               w_alu_acc;
  logic               w_st_acc;
  logic               w_ld_acc;
  logic               w_st_done;
  logic               w_ld_done;
  logic               w_retire;

  logic               r_req;
  logic               r_we;
  logic [XLEN-1:0]    r_addr;
  logic [XLEN-1:0]    r_wdata;
  logic [BW-1:0]      r_be;
  logic [REG_AW-1:0]  r_ld_rd;

  logic               r_wr_en;
  logic [REG_AW-1:0]  r_wr_addr;
  logic [XLEN-1:0]    r_wr_data;
  logic [CNT_W-1:0]   r_cnt;

  assign w_accept  = bus.ex_valid & (r_state == WB_IDLE);
  assign w_alu_acc = w_accept & (bus.ex_op == WB_OP_ALU);
  assign w_st_acc  = w_accept & (bus.ex_op == WB_OP_STORE);
  assign w_ld_acc  = w_accept & (bus.ex_op == WB_OP_LOAD);
  assign w_st_done = (r_state == WB_ST_REQ) & bus.dbus_gnt;
  // A load completes on rvalid alone in LD_WAIT, or on gnt+rvalid together in LD_REQ.
  assign w_ld_done = ((r_state == WB_LD_REQ) & bus.dbus_gnt & bus.dbus_rvalid) |
                     ((r_state == WB_LD_WAIT) & bus.dbus_rvalid);
  assign w_retire  = w_alu_acc | w_st_done | w_ld_done;

  // Next-state decode of the bus-transaction FSM
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WB_IDLE: begin
        if (w_st_acc)      w_state_nxt = WB_ST_REQ;
        else if (w_ld_acc) w_state_nxt = WB_LD_REQ;
        else               w_state_nxt = WB_IDLE;
      end
      WB_ST_REQ: begin
        if (bus.dbus_gnt) w_state_nxt = WB_IDLE;
        else              w_state_nxt = WB_ST_REQ;
      end
      WB_LD_REQ: begin
        if (bus.dbus_gnt && bus.dbus_rvalid) w_state_nxt = WB_IDLE;
        else if (bus.dbus_gnt)               w_state_nxt = WB_LD_WAIT;
        else                                 w_state_nxt = WB_LD_REQ;
      end
      WB_LD_WAIT: begin
        if (bus.dbus_rvalid) w_state_nxt = WB_IDLE;
        else                 w_state_nxt = WB_LD_WAIT;
      end
      default: w_state_nxt = WB_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WB_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Data-bus request fields, captured on a memory-op accept and held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= {XLEN{1'b0}};
      r_wdata <= {XLEN{1'b0}};
      r_be    <= {BW{1'b0}};
      r_ld_rd <= {REG_AW{1'b0}};
    end else begin
      r_req <= (w_state_nxt == WB_ST_REQ) | (w_state_nxt == WB_LD_REQ);
      if (w_st_acc | w_ld_acc) begin
        r_we    <= w_st_acc;
        r_addr  <= bus.ex_result;
        r_wdata <= bus.ex_wdata;
        r_be    <= bus.ex_be;
        r_ld_rd <= bus.ex_rd;
      end
    end
  end

  // Regfile write port: one-cycle strobe, suppressed for x0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= {REG_AW{1'b0}};
      r_wr_data <= {XLEN{1'b0}};
    end else if (w_alu_acc) begin
      r_wr_en   <= (bus.ex_rd != {REG_AW{1'b0}});
      r_wr_addr <= bus.ex_rd;
      r_wr_data <= bus.ex_result;
    end else if (w_ld_done) begin
      r_wr_en   <= (r_ld_rd != {REG_AW{1'b0}});
      r_wr_addr <= r_ld_rd;
      r_wr_data <= bus.dbus_rdata;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  // Retired-op counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_cnt <= {CNT_W{1'b0}};
    else if (w_retire) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    else               r_cnt <= r_cnt;
  end

  assign bus.ex_ready    = (r_state == WB_IDLE);
  assign bus.dbus_req    = r_req;
  assign bus.dbus_we     = r_we;
  assign bus.dbus_addr   = r_addr;
  assign bus.dbus_wdata  = r_wdata;
  assign bus.dbus_be     = r_be;
  assign bus.wr_rd_en    = r_wr_en;
  assign bus.wr_rd_addr  = r_wr_addr;
  assign bus.wr_rd_data  = r_wr_data;
  assign bus.retired_cnt = r_cnt;

endmodule

// File: tb/tb_wb_lsu_stage.sv
// Randomized self-checking bench for wb_lsu_stage; a narrow counter makes wrap-around reachable.
module tb_wb_lsu_stage;
  import wb_pkg::*;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int unsigned exp_cnt;

  wb_lsu_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus_if ();

  wb_lsu_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic retire();
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
  endtask

  task automatic check_wb(input logic [4:0] rd, input logic [31:0] data);
    check_eq("wr_en", 64'(bus_if.wr_rd_en), 64'(rd != 5'd0));
    if (rd != 5'd0) begin
      check_eq("wr_addr", 64'(bus_if.wr_rd_addr), 64'(rd));
      check_eq("wr_data", 64'(bus_if.wr_rd_data), 64'(data));
    end
    check_eq("cnt", 64'(bus_if.retired_cnt), 64'(exp_cnt));
    check_eq("ready_after", 64'(bus_if.ex_ready), 64'd1);
  endtask

  // Async reset in the middle of a cycle; outputs must clear before the next edge.
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    check_eq("rst_req",     64'(bus_if.dbus_req),    64'd0);
    check_eq("rst_we",      64'(bus_if.dbus_we),     64'd0);
    check_eq("rst_wr_en",   64'(bus_if.wr_rd_en),    64'd0);
    check_eq("rst_addr",    64'(bus_if.dbus_addr),   64'd0);
    check_eq("rst_wdata",   64'(bus_if.dbus_wdata),  64'd0);
    check_eq("rst_be",      64'(bus_if.dbus_be),     64'd0);
    check_eq("rst_wr_addr", 64'(bus_if.wr_rd_addr),  64'd0);
    check_eq("rst_wr_data", 64'(bus_if.wr_rd_data),  64'd0);
    check_eq("rst_cnt",     64'(bus_if.retired_cnt), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("rst_ready", 64'(bus_if.ex_ready), 64'd1);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] res,
                       input logic [31:0] wd, input logic [3:0] be, input int gdly,
                       input int rdly, input bit same, input logic [31:0] rdata);
    logic is_st;
    is_st = (op == 2'd2);
    check_eq("ready_pre", 64'(bus_if.ex_ready), 64'd1);
    bus_if.ex_valid  = 1'b1;
    bus_if.ex_op     = wb_op_e'(op);
    bus_if.ex_rd     = rd;
    bus_if.ex_result = res;
    bus_if.ex_wdata  = wd;
    bus_if.ex_be     = be;
    if (op < 2'd2) begin
      bus_if.dbus_gnt    = 1'($urandom_range(0, 1));
      bus_if.dbus_rvalid = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    bus_if.ex_valid    = 1'b0;
    bus_if.dbus_gnt    = 1'b0;
    bus_if.dbus_rvalid = 1'b0;
    bus_if.ex_rd       = 5'($urandom);
    bus_if.ex_result   = $urandom;
    bus_if.ex_wdata    = $urandom;
    bus_if.ex_be       = 4'($urandom);
    if (op == 2'd0) begin
      check_eq("none_wr_en", 64'(bus_if.wr_rd_en), 64'd0);
      check_eq("none_cnt", 64'(bus_if.retired_cnt), 64'(exp_cnt));
      check_eq("none_ready", 64'(bus_if.ex_ready), 64'd1);
    end else if (op == 2'd1) begin
      retire();
      check_wb(rd, res);
    end else begin
      for (int c = 0; c <= gdly; c++) begin
        check_eq("req_held", 64'(bus_if.dbus_req),  64'd1);
        check_eq("req_we",   64'(bus_if.dbus_we),   64'(is_st));
        check_eq("req_addr", 64'(bus_if.dbus_addr), 64'(res));
        check_eq("req_be",   64'(bus_if.dbus_be),   64'(be));
        if (is_st) check_eq("req_wdata", 64'(bus_if.dbus_wdata), 64'(wd));
        check_eq("req_ready", 64'(bus_if.ex_ready), 64'd0);
        check_eq("req_wr_en", 64'(bus_if.wr_rd_en), 64'd0);
        if (c < gdly) begin
          bus_if.dbus_rvalid = is_st ? 1'($urandom_range(0, 1)) : 1'b0;
          @(posedge clk); #1;
          bus_if.dbus_rvalid = 1'b0;
        end
      end
      bus_if.dbus_gnt = 1'b1;
      if (!is_st && same) begin
        bus_if.dbus_rvalid = 1'b1;
        bus_if.dbus_rdata  = rdata;
      end
      @(posedge clk); #1;
      bus_if.dbus_gnt    = 1'b0;
      bus_if.dbus_rvalid = 1'b0;
      bus_if.dbus_rdata  = $urandom;
      check_eq("req_drop", 64'(bus_if.dbus_req), 64'd0);
      if (is_st) begin
        retire();
        check_eq("st_cnt", 64'(bus_if.retired_cnt), 64'(exp_cnt));
        check_eq("st_ready", 64'(bus_if.ex_ready), 64'd1);
      end else if (same) begin
        retire();
        check_wb(rd, rdata);
      end else begin
        for (int c = 1; c <= rdly; c++) begin
          check_eq("ldw_ready", 64'(bus_if.ex_ready), 64'd0);
          check_eq("ldw_wr_en", 64'(bus_if.wr_rd_en), 64'd0);
          check_eq("ldw_cnt", 64'(bus_if.retired_cnt), 64'(exp_cnt));
          if (c < rdly) bus_if.dbus_gnt = 1'($urandom_range(0, 1));
          else begin
            bus_if.dbus_rvalid = 1'b1;
            bus_if.dbus_rdata  = rdata;
          end
          @(posedge clk); #1;
          bus_if.dbus_gnt    = 1'b0;
          bus_if.dbus_rvalid = 1'b0;
          bus_if.dbus_rdata  = $urandom;
        end
        retire();
        check_wb(rd, rdata);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_cnt  = 0;
    rst_n    = 1'b1;
    bus_if.ex_valid    = 1'b0;
    bus_if.ex_op       = WB_OP_NONE;
    bus_if.ex_rd       = 5'd0;
    bus_if.ex_result   = 32'd0;
    bus_if.ex_wdata    = 32'd0;
    bus_if.ex_be       = 4'd0;
    bus_if.dbus_gnt    = 1'b0;
    bus_if.dbus_rvalid = 1'b0;
    bus_if.dbus_rdata  = 32'd0;

    apply_reset();

    do_op(2'd1, 5'd5, 32'h1234,     32'd0,        4'h0, 0, 0, 1'b0, 32'd0);
    check_eq("t1_cnt_is_1", 64'(bus_if.retired_cnt), 64'd1);
    do_op(2'd2, 5'd0, 32'h100,      32'hDEADBEEF, 4'hF, 3, 0, 1'b0, 32'd0);
    do_op(2'd3, 5'd7, 32'h200,      32'd0,        4'hF, 1, 2, 1'b0, 32'hCAFE);
    do_op(2'd3, 5'd9, 32'h204,      32'd0,        4'h3, 0, 0, 1'b1, 32'h5555AAAA);
    do_op(2'd1, 5'd0, 32'h77,       32'd0,        4'h0, 0, 0, 1'b0, 32'd0);
    do_op(2'd0, 5'd3, 32'h99,       32'd0,        4'h0, 0, 0, 1'b0, 32'd0);
    for (int k = 0; k < 6; k++)
      do_op(2'd1, 5'(k + 1), 32'h1000 + 32'(k), 32'd0, 4'h0, 0, 0, 1'b0, 32'd0);

    for (int n = 0; n < 150; n++) begin
      logic [1:0] rop;
      logic [4:0] rrd;
      rop = 2'($urandom_range(0, 3));
      rrd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      do_op(rop, rrd, $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
            int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), $urandom);
    end

    // Reset while a load sits in LD_WAIT; the late response must be ignored.
    do_op(2'd1, 5'd4, 32'h44, 32'd0, 4'h0, 0, 0, 1'b0, 32'd0);
    bus_if.ex_valid = 1'b1; bus_if.ex_op = WB_OP_LOAD; bus_if.ex_rd = 5'd11;
    bus_if.ex_result = 32'h300; bus_if.ex_be = 4'hF;
    @(posedge clk); #1;
    bus_if.ex_valid = 1'b0;
    bus_if.dbus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_if.dbus_gnt = 1'b0;
    check_eq("t6_in_wait", 64'(bus_if.ex_ready), 64'd0);
    apply_reset();
    bus_if.dbus_rvalid = 1'b1; bus_if.dbus_gnt = 1'b1; bus_if.dbus_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    bus_if.dbus_rvalid = 1'b0; bus_if.dbus_gnt = 1'b0;
    check_eq("t6_no_write", 64'(bus_if.wr_rd_en),    64'd0);
    check_eq("t6_idle",     64'(bus_if.ex_ready),    64'd1);
    check_eq("t6_cnt",      64'(bus_if.retired_cnt), 64'd0);

    // Reset while a store request is pending; req must drop without a clock.
    bus_if.ex_valid = 1'b1; bus_if.ex_op = WB_OP_STORE; bus_if.ex_result = 32'h400;
    @(posedge clk); #1;
    bus_if.ex_valid = 1'b0;
    check_eq("t7_req_up", 64'(bus_if.dbus_req), 64'd1);
    apply_reset();
    do_op(2'd1, 5'd2, 32'h22, 32'd0, 4'h0, 0, 0, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
